// File: rtl/ycc_pkg.sv
// ycc_pkg: shared fixed-point constants for the BT.601 full-range RGB to YCbCr converter
package ycc_pkg;
  localparam int FRAC = 14;
  localparam int ACC_W = 26;
  localparam logic signed [ACC_W-1:0] C_Y_R = 26'sd4899;
  localparam logic signed [ACC_W-1:0] C_Y_G = 26'sd9617;
  localparam logic signed [ACC_W-1:0] C_Y_B = 26'sd1868;
  localparam logic signed [ACC_W-1:0] C_CB_R = -26'sd2765;
  localparam logic signed [ACC_W-1:0] C_CB_G = -26'sd5427;
  localparam logic signed [ACC_W-1:0] C_CB_B = 26'sd8192;
  localparam logic signed [ACC_W-1:0] C_CR_R = 26'sd8192;
  localparam logic signed [ACC_W-1:0] C_CR_G = -26'sd6860;
  localparam logic signed [ACC_W-1:0] C_CR_B = -26'sd1332;
  localparam logic signed [ACC_W-1:0] C_OFS = ACC_W'(128) <<< FRAC;
  localparam logic signed [ACC_W-1:0] C_RND = ACC_W'(1) <<< (FRAC - 1);
endpackage

// File: rtl/ycc_dot3.sv
// ycc_dot3: registered three-term dot product with offset, round-half-up and 0..255 saturation
module ycc_dot3
  import ycc_pkg::*;
#(
  parameter int FRAC = 14,
  parameter logic signed [ACC_W-1:0] CA = '0,
  parameter logic signed [ACC_W-1:0] CB = '0,
  parameter logic signed [ACC_W-1:0] CC = '0,
  parameter logic signed [ACC_W-1:0] OFS = '0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] c,
  output logic [7:0] y
);
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) <<< (FRAC - 1);
  localparam logic [7:0] BLACK = 8'(OFS >>> FRAC);
  logic signed [ACC_W-1:0] pa_d, pb_d, pc_d, pa_q, pb_q, pc_q;
  logic signed [ACC_W-1:0] acc, sh;
  logic [7:0] y_d, y_q;
  // products of zero-extended pixels with the signed coefficients
  always_comb begin
    pa_d = ACC_W'(a) * CA;
    pb_d = ACC_W'(b) * CB;
    pc_d = ACC_W'(c) * CC;
  end
  // sum, offset, round by truncating after adding half, then clamp
  always_comb begin
    acc = pa_q + pb_q + pc_q + OFS + RND;
    sh = acc >>> FRAC;
    y_d = sh < 0 ? 8'd0 : sh > 255 ? 8'd255 : sh[7:0];
  end
  // product and output registers; reset loads the black code of this channel
  always_ff @(posedge clk) begin
    pa_q <= rst ? '0 : pa_d;
    pb_q <= rst ? '0 : pb_d;
    pc_q <= rst ? '0 : pc_d;
    y_q <= rst ? BLACK : y_d;
  end
  assign y = y_q;
endmodule

// File: rtl/rgb_to_ycbcr.sv
// rgb_to_ycbcr: 3-cycle free-running RGB to full-range BT.601 YCbCr converter
module rgb_to_ycbcr
  import ycc_pkg::*;
#(
  parameter int FRAC = ycc_pkg::FRAC
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] R,
  input  logic [8:0] G,
  input  logic [8:0] B,
  output logic [7:0] Y,
  output logic [7:0] Cb,
  output logic [7:0] Cr
);
  localparam logic signed [ACC_W-1:0] OFS = ACC_W'(128) <<< FRAC;
  logic [7:0] r_d, g_d, b_d, r_q, g_q, b_q;
  // negative inputs clip to zero
  always_comb begin
    r_d = R[8] ? 8'd0 : R[7:0];
    g_d = G[8] ? 8'd0 : G[7:0];
    b_d = B[8] ? 8'd0 : B[7:0];
  end
  // clipped pixel register
  always_ff @(posedge clk) begin
    r_q <= rst ? '0 : r_d;
    g_q <= rst ? '0 : g_d;
    b_q <= rst ? '0 : b_d;
  end
  ycc_dot3 #(.FRAC(FRAC), .CA(C_Y_R), .CB(C_Y_G), .CC(C_Y_B), .OFS('0)) u_y (
    .clk(clk), .rst(rst), .a(r_q), .b(g_q), .c(b_q), .y(Y)
  );
  ycc_dot3 #(.FRAC(FRAC), .CA(C_CB_R), .CB(C_CB_G), .CC(C_CB_B), .OFS(OFS)) u_cb (
    .clk(clk), .rst(rst), .a(r_q), .b(g_q), .c(b_q), .y(Cb)
  );
  ycc_dot3 #(.FRAC(FRAC), .CA(C_CR_R), .CB(C_CR_G), .CC(C_CR_B), .OFS(OFS)) u_cr (
    .clk(clk), .rst(rst), .a(r_q), .b(g_q), .c(b_q), .y(Cr)
  );
endmodule

// File: tb/tb_rgb_to_ycbcr.sv
// tb_rgb_to_ycbcr: directed and random scoreboard bench for the colour-space converter
module tb_rgb_to_ycbcr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [8:0] R = '0, G = '0, B = '0;
  logic [7:0] Y, Cb, Cr;
  int errs = 0;
  int checks = 0;
  logic [23:0] q[$];
  localparam logic [23:0] BLK = 24'h008080;
  logic [26:0] px[8] = '{
    {9'd0, 9'd0, 9'd0}, {9'd255, 9'd0, 9'd0}, {9'd0, 9'd255, 9'd0}, {9'd0, 9'd0, 9'd255},
    {9'd255, 9'd255, 9'd0}, {9'd0, 9'd255, 9'd255}, {9'd255, 9'd0, 9'd255}, {9'd255, 9'd255, 9'd255}
  };
  logic [23:0] ex[8] = '{
    {8'd0, 8'd128, 8'd128}, {8'd76, 8'd85, 8'd255}, {8'd150, 8'd44, 8'd21}, {8'd29, 8'd255, 8'd107},
    {8'd226, 8'd1, 8'd149}, {8'd179, 8'd171, 8'd1}, {8'd105, 8'd212, 8'd235}, {8'd255, 8'd128, 8'd128}
  };

  rgb_to_ycbcr dut (
    .clk(clk), .rst(rst), .R(R), .G(G), .B(B), .Y(Y), .Cb(Cb), .Cr(Cr)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] sat(input int v);
    return v < 0 ? 8'd0 : v > 255 ? 8'd255 : 8'(v);
  endfunction

  function automatic logic [23:0] mdl(input logic [26:0] p);
    int r, g, b;
    r = p[26] ? 0 : int'(p[25:18]);
    g = p[17] ? 0 : int'(p[16:9]);
    b = p[8] ? 0 : int'(p[7:0]);
    return {sat((4899 * r + 9617 * g + 1868 * b + 8192) >>> 14),
            sat((-2765 * r - 5427 * g + 8192 * b + 2105344) >>> 14),
            sat((8192 * r - 6860 * g - 1332 * b + 2105344) >>> 14)};
  endfunction

  task automatic step(input logic [26:0] p, input logic rs, input logic [23:0] e, input string tag);
    logic [23:0] want;
    @(negedge clk);
    {R, G, B} = p;
    rst = rs;
    @(posedge clk);
    #1;
    if (rs) begin
      q.delete();
      q.push_back(BLK);
      q.push_back(BLK);
      want = BLK;
    end else begin
      q.push_back(e);
      want = q.pop_front();
    end
    checks++;
    assert ({Y, Cb, Cr} === want)
    else begin
      errs++;
      $error("FAIL %s: got %h want %h", tag, {Y, Cb, Cr}, want);
    end
  endtask

  initial begin
    logic [26:0] p;
    step({9'h123, 9'h0AA, 9'h1F0}, 1'b1, BLK, "reset0");
    step({9'h055, 9'h1FF, 9'h080}, 1'b1, BLK, "reset1");
    for (int i = 0; i < 8; i++)
      for (int k = 0; k < 4; k++) step(px[i], 1'b0, ex[i], $sformatf("hold%0d", i));
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < 8; i++) step(px[i], 1'b0, ex[i], $sformatf("seq%0d", i));
    for (int k = 0; k < 3; k++) step({9'h1FF, 9'h100, 9'h180}, 1'b0, BLK, "clip");
    for (int i = 0; i < 20; i++) begin
      p = {9'($urandom_range(0, 511)), 9'($urandom_range(0, 511)), 9'($urandom_range(0, 511))};
      step(p, 1'b0, mdl(p), $sformatf("rand%0d", i));
    end
    for (int i = 1; i < 8; i++) step(px[i], 1'b0, ex[i], "pre_rst");
    step(px[7], 1'b1, BLK, "mid_rst");
    for (int i = 1; i < 8; i++) step(px[i], 1'b0, ex[i], $sformatf("post_rst%0d", i));
    for (int k = 0; k < 2; k++) step(px[0], 1'b0, ex[0], "drain");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
